fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO among NUM_REQ producers, with
// shadow occupancy tracking and a bounded burst lock for the current owner.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int LVL_W     = $clog2(DEPTH + 1),
    localparam int OWN_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_r_en,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    output logic [LVL_W-1:0]              level,
    output logic [OWN_W-1:0]              owner,
    output logic                          ovf_err,
    output logic                          dbg_state
);

    // Handshake: a producer raises req[i] with its data slice stable and holds both
    // until the cycle in which gnt[i] is high; that data is taken at the closing
    // posedge. gnt[i] is never high while req[i] is low.

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [OWN_W-1:0]        r_owner;
    logic [CNT_W-1:0]        r_burst_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [LVL_W-1:0]        r_level;
    logic                    r_w_en;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_ovf;

    logic                    w_space;
    logic                    w_rd_ok;
    logic                    w_rd_dec;
    logic                    w_arb_found;
    logic [OWN_W-1:0]        w_arb_idx;
    logic                    w_own_req;
    logic                    w_grant;
    logic [OWN_W-1:0]        w_gnt_idx;
    logic [DATA_WIDTH-1:0]   w_gnt_data;

    // First requester after 'last', wrapping; 'last' itself is searched last.
    function automatic logic [OWN_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [OWN_W-1:0]   last);
        logic             found;
        logic [OWN_W-1:0] pick;
        logic [OWN_W-1:0] cand;
        int               idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = OWN_W'(idx);
            if (!found && r[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return {found, pick};
    endfunction

    always_comb begin
        w_space  = (r_level < LVL_W'(DEPTH));
        w_rd_ok  = fifo_r_en & ~fifo_empty;
        w_rd_dec = w_rd_ok & (r_level != '0);
        {w_arb_found, w_arb_idx} = rr_pick(req, r_owner);
        w_own_req = req[r_owner];
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_gnt_idx    = r_owner;
        w_cnt_next   = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_space && w_arb_found) begin
                    w_grant    = 1'b1;
                    w_gnt_idx  = w_arb_idx;
                    w_cnt_next = CNT_W'(1);
                    if (MAX_BURST > 1) begin
                        w_state_next = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (w_own_req && (r_burst_cnt < CNT_W'(MAX_BURST))) begin
                    // Owner keeps the port; without space it simply waits here.
                    if (w_space) begin
                        w_grant    = 1'b1;
                        w_gnt_idx  = r_owner;
                        w_cnt_next = r_burst_cnt + CNT_W'(1);
                    end
                end else if (w_space && w_arb_found) begin
                    w_grant    = 1'b1;
                    w_gnt_idx  = w_arb_idx;
                    w_cnt_next = CNT_W'(1);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // gnt must read zero while reset is held, even though req may be high.
        if (!rst_n) begin
            w_grant = 1'b0;
        end
    end

    always_comb begin
        w_gnt_data = '0;
        gnt        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (OWN_W'(i) == w_gnt_idx) begin
                w_gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                gnt[i]     = w_grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_W'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_burst_cnt <= w_cnt_next;
            if (w_grant) begin
                r_owner <= w_gnt_idx;
            end
        end
    end

    // Level only moves when exactly one of grant/read happens; grants are gated by space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (w_grant && !w_rd_dec) begin
            r_level <= r_level + LVL_W'(1);
        end else if (!w_grant && w_rd_dec) begin
            r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_en <= 1'b0;
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_w_en <= w_grant;
            if (w_grant) begin
                r_data <= w_gnt_data;
            end
            if (r_w_en && fifo_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign fifo_w_en    = r_w_en;
    assign fifo_data_in = r_data;
    assign level        = r_level;
    assign owner        = r_owner;
    assign ovf_err      = r_ovf;
    assign dbg_state    = r_state;

endmodule
